// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the two-port SDRAM request arbiter.
package dram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Port indices: the CPU core is port 0, the second bus master is port 1.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;

    // Read data returned to a port whose transaction was aborted by the watchdog.
    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant. On a tie the port that did
// not win last time is chosen; a lone requester always wins.
module rr_arb2
    import dram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // Pick the winner from the two request lines and the previous grant.
    always_comb begin
        grant_valid = req0 | req1;
        grant       = PORT_CPU;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = PORT_AUX;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one sdram_controller3 request interface between the CPU
// (port 0) and an auxiliary master (port 1). One transaction is in flight at a
// time; the completion strobe and read data go back to the granted port only.
// Optional macro DRAM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a stuck
// transfer after TIMEOUT_CYCLES and pulses timeout_err.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_read,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_data_valid,
    output logic              p0_write_complete,

    input  logic              p1_req_read,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_data_valid,
    output logic              p1_write_complete,

    output logic [ADDR_W-1:0] ctrl_address,
    output logic              ctrl_req_read,
    output logic              ctrl_req_write,
    output logic [DATA_W-1:0] ctrl_data_in,
    input  logic [DATA_W-1:0] ctrl_data_out,
    input  logic              ctrl_data_valid,
    input  logic              ctrl_write_complete,

    output logic              timeout_err
);

    // Per-port views of the request inputs so the datapath can index by grant.
    logic              req_rd   [2];
    logic              req_wr   [2];
    logic [ADDR_W-1:0] addr_in  [2];
    logic [DATA_W-1:0] wdata_in [2];
    logic [1:0]        port_req;

    arb_state_t        state_reg;
    logic              last_grant_reg;
    logic              grant_reg;
    logic [ADDR_W-1:0] ctrl_address_reg;
    logic [DATA_W-1:0] ctrl_data_in_reg;
    logic              ctrl_req_read_reg;
    logic              ctrl_req_write_reg;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [1:0]        data_valid_reg;
    logic [1:0]        write_complete_reg;

    logic              grant_valid;
    logic              grant;
    logic              done_hit;

    assign req_rd[0]   = p0_req_read;
    assign req_rd[1]   = p1_req_read;
    assign req_wr[0]   = p0_req_write;
    assign req_wr[1]   = p1_req_write;
    assign addr_in[0]  = p0_addr;
    assign addr_in[1]  = p1_addr;
    assign wdata_in[0] = p0_wdata;
    assign wdata_in[1] = p1_wdata;

    // A port is blind while its own completion pulse is high, so a client that
    // drops its request in response to the pulse is never re-issued.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_req[gi] = (req_rd[gi] | req_wr[gi])
                                & ~(data_valid_reg[gi] | write_complete_reg[gi]);
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .req0        (port_req[0]),
        .req1        (port_req[1]),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Only the completion matching the issued type ends the transaction.
    assign done_hit = (ctrl_req_read_reg  & ctrl_data_valid)
                    | (ctrl_req_write_reg & ctrl_write_complete);

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] busy_cnt_reg;
    logic             timeout_err_reg;
    logic             timeout_hit;

    // Counter value k means k full BUSY cycles have elapsed before this edge.
    assign timeout_hit = (busy_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbiter FSM: issue from IDLE, hold the request in BUSY until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            last_grant_reg     <= PORT_AUX;
            grant_reg          <= PORT_CPU;
            ctrl_address_reg   <= '0;
            ctrl_data_in_reg   <= '0;
            ctrl_req_read_reg  <= 1'b0;
            ctrl_req_write_reg <= 1'b0;
            data_valid_reg     <= '0;
            write_complete_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
`ifdef DRAM_ARB_TIMEOUT_EN
            busy_cnt_reg       <= '0;
            timeout_err_reg    <= 1'b0;
`endif
        end else begin
            data_valid_reg     <= '0;
            write_complete_reg <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            timeout_err_reg    <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        // Read wins over write within a port; the write stays pending.
                        ctrl_address_reg   <= addr_in[grant];
                        ctrl_data_in_reg   <= wdata_in[grant];
                        ctrl_req_read_reg  <= req_rd[grant];
                        ctrl_req_write_reg <= ~req_rd[grant];
                        grant_reg          <= grant;
                        last_grant_reg     <= grant;
                        state_reg          <= BUSY;
`ifdef DRAM_ARB_TIMEOUT_EN
                        busy_cnt_reg       <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (done_hit) begin
                        if (ctrl_req_read_reg) begin
                            rdata_reg[grant_reg] <= ctrl_data_out;
                        end
                        data_valid_reg[grant_reg]     <= ctrl_req_read_reg;
                        write_complete_reg[grant_reg] <= ctrl_req_write_reg;
                        ctrl_req_read_reg             <= 1'b0;
                        ctrl_req_write_reg            <= 1'b0;
                        state_reg                     <= IDLE;
`ifdef DRAM_ARB_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        // Abort: complete the port with poison data and flag it.
                        if (ctrl_req_read_reg) begin
                            rdata_reg[grant_reg] <= DATA_W'(ABORT_DATA);
                        end
                        data_valid_reg[grant_reg]     <= ctrl_req_read_reg;
                        write_complete_reg[grant_reg] <= ctrl_req_write_reg;
                        ctrl_req_read_reg             <= 1'b0;
                        ctrl_req_write_reg            <= 1'b0;
                        timeout_err_reg               <= 1'b1;
                        state_reg                     <= IDLE;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg + 1'b1;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ctrl_address      = ctrl_address_reg;
    assign ctrl_data_in      = ctrl_data_in_reg;
    assign ctrl_req_read     = ctrl_req_read_reg;
    assign ctrl_req_write    = ctrl_req_write_reg;
    assign p0_rdata          = rdata_reg[0];
    assign p1_rdata          = rdata_reg[1];
    assign p0_data_valid     = data_valid_reg[0];
    assign p1_data_valid     = data_valid_reg[1];
    assign p0_write_complete = write_complete_reg[0];
    assign p1_write_complete = write_complete_reg[1];

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter. Stimulus pushes expected
// controller issues and expected port completions into queues; independent
// monitors pop and compare whenever the DUT issues or completes. A small
// controller model answers requests after a programmable latency.
// Build with +define+DRAM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_dram_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct packed {
        logic          port;
        logic          rd;
        logic [DW-1:0] data;
        logic          to;
    } done_t;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          abort_rst;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic          req_read  [2];
    logic          req_write [2];
    logic [AW-1:0] addr      [2];
    logic [DW-1:0] wdata     [2];
    logic [DW-1:0] rdata     [2];
    logic          dv        [2];
    logic          wc        [2];

    logic [AW-1:0] ctrl_address;
    logic          ctrl_req_read;
    logic          ctrl_req_write;
    logic [DW-1:0] ctrl_data_in;
    logic [DW-1:0] ctrl_data_out;
    logic          ctrl_data_valid;
    logic          ctrl_write_complete;
    logic          timeout_err;

    int    checks = 0;
    int    errors = 0;
    iss_t  iss_q[$];
    done_t done_q[$];
    op_t   op0_q[$];
    op_t   op1_q[$];
    bit    client_busy [2];
    int    ctrl_latency = 3;
    bit    ctrl_enable  = 1'b1;
    bit    inject_wrong = 1'b0;
    int    last_high_cycles = 0;

    always #5 clk = ~clk;

    dram_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .p0_req_read         (req_read[0]),
        .p0_req_write        (req_write[0]),
        .p0_addr             (addr[0]),
        .p0_wdata            (wdata[0]),
        .p0_rdata            (rdata[0]),
        .p0_data_valid       (dv[0]),
        .p0_write_complete   (wc[0]),
        .p1_req_read         (req_read[1]),
        .p1_req_write        (req_write[1]),
        .p1_addr             (addr[1]),
        .p1_wdata            (wdata[1]),
        .p1_rdata            (rdata[1]),
        .p1_data_valid       (dv[1]),
        .p1_write_complete   (wc[1]),
        .ctrl_address        (ctrl_address),
        .ctrl_req_read       (ctrl_req_read),
        .ctrl_req_write      (ctrl_req_write),
        .ctrl_data_in        (ctrl_data_in),
        .ctrl_data_out       (ctrl_data_out),
        .ctrl_data_valid     (ctrl_data_valid),
        .ctrl_write_complete (ctrl_write_complete),
        .timeout_err         (timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s at %0t", name, detail, $time);
    endtask

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        if (a == 24'h000010) return 32'h12345678;
        return {8'hD0, a};
    endfunction

    task automatic exp_iss(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iss_t e;
        e.rd = rd; e.addr = a; e.wdata = d;
        iss_q.push_back(e);
    endtask

    task automatic exp_done(input logic port, input logic rd, input logic [DW-1:0] d, input logic to);
        done_t e;
        e.port = port; e.rd = rd; e.data = d; e.to = to;
        done_q.push_back(e);
    endtask

    task automatic push_op(input int p, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ab);
        op_t o;
        o.rd = rd; o.wr = wr; o.addr = a; o.wdata = d; o.abort_rst = ab;
        if (p == 0) op0_q.push_back(o);
        else        op1_q.push_back(o);
    endtask

    // Client: holds a level request until its completion pulse, dropping it
    // only after the clock edge that ends the pulse.
    task automatic client(input int p);
        op_t op;
        bit  have;
        bit  drop_rd;
        bit  drop_wr;
        int  budget;
        forever begin
            @(negedge clk);
            have = 1'b0;
            if (p == 0 && op0_q.size() > 0) begin
                op = op0_q.pop_front(); have = 1'b1;
            end else if (p == 1 && op1_q.size() > 0) begin
                op = op1_q.pop_front(); have = 1'b1;
            end
            if (have) begin
                client_busy[p] = 1'b1;
                addr[p]      = op.addr;
                wdata[p]     = op.wdata;
                req_read[p]  = op.rd;
                req_write[p] = op.wr;
                budget = 0;
                while (req_read[p] || req_write[p]) begin
                    @(negedge clk);
                    budget++;
                    if (!rst_n && op.abort_rst) begin
                        req_read[p]  = 1'b0;
                        req_write[p] = 1'b0;
                    end else if (dv[p] || wc[p]) begin
                        drop_rd = dv[p];
                        drop_wr = wc[p];
                        @(posedge clk);
                        #1;
                        if (drop_rd) req_read[p]  = 1'b0;
                        if (drop_wr) req_write[p] = 1'b0;
                    end else if (budget > 300) begin
                        fail_msg("client_wait", $sformatf("port %0d never completed", p));
                        req_read[p]  = 1'b0;
                        req_write[p] = 1'b0;
                    end
                end
                client_busy[p] = 1'b0;
            end
        end
    endtask

    initial client(0);
    initial client(1);

    // Controller model: answers after ctrl_latency cycles of request, optionally
    // injecting a wrong-type data_valid strobe during writes.
    initial begin : ctrl_model
        int  cnt;
        bit  answered;
        cnt = 0;
        answered = 1'b0;
        ctrl_data_out       = '0;
        ctrl_data_valid     = 1'b0;
        ctrl_write_complete = 1'b0;
        forever begin
            @(negedge clk);
            ctrl_data_valid     = 1'b0;
            ctrl_write_complete = 1'b0;
            if (!rst_n || !(ctrl_req_read || ctrl_req_write)) begin
                cnt = 0;
                answered = 1'b0;
            end else if (!answered) begin
                cnt++;
                if (inject_wrong && ctrl_req_write && cnt == 2) begin
                    ctrl_data_valid = 1'b1;
                    ctrl_data_out   = 32'hBAD0BAD0;
                end
                if (ctrl_enable && cnt == ctrl_latency) begin
                    if (ctrl_req_read) begin
                        ctrl_data_valid = 1'b1;
                        ctrl_data_out   = model_data(ctrl_address);
                    end else begin
                        ctrl_write_complete = 1'b1;
                    end
                    answered = 1'b1;
                end
            end
        end
    end

    // Issue monitor: every new controller request must match the next expected issue.
    initial begin : issue_mon
        bit   req_prev;
        logic req_now;
        iss_t cur;
        iss_t e;
        int   hc;
        req_prev = 1'b0;
        hc = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            req_now = ctrl_req_read | ctrl_req_write;
            if (req_now && !req_prev) begin
                cur.rd = ctrl_req_read; cur.addr = ctrl_address; cur.wdata = ctrl_data_in;
                hc = 1;
                check("issue_one_type", 64'(ctrl_req_read & ctrl_req_write), 64'(0));
                if (iss_q.size() == 0) begin
                    fail_msg("issue_unexpected", $sformatf("addr %0h rd %0b", ctrl_address, ctrl_req_read));
                end else begin
                    e = iss_q.pop_front();
                    check("issue_read", 64'(ctrl_req_read), 64'(e.rd));
                    check("issue_addr", 64'(ctrl_address), 64'(e.addr));
                    check("issue_wdata", 64'(ctrl_data_in), 64'(e.wdata));
                end
            end else if (req_now) begin
                hc++;
                check("busy_hold", {6'd0, ctrl_req_read, ctrl_req_write, ctrl_address, ctrl_data_in},
                      {6'd0, cur.rd, ~cur.rd, cur.addr, cur.wdata});
            end else if (req_prev) begin
                last_high_cycles = hc;
            end
            req_prev = req_now;
        end
    end

    // Completion monitor: every port pulse must match the next expected completion.
    initial begin : done_mon
        done_t e;
        bit    any;
        forever begin
            @(negedge clk);
            any = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (dv[p] || wc[p]) begin
                    any = 1'b1;
                    if (done_q.size() == 0) begin
                        fail_msg("done_unexpected", $sformatf("port %0d dv %0b wc %0b", p, dv[p], wc[p]));
                    end else begin
                        e = done_q.pop_front();
                        check("done_port", 64'(p), 64'(e.port));
                        check("done_kind", 64'({dv[p], wc[p]}), 64'(e.rd ? 2'b10 : 2'b01));
                        if (e.rd) check("done_rdata", 64'(rdata[p]), 64'(e.data));
                        check("done_timeout_err", 64'(timeout_err), 64'(e.to));
                    end
                end
            end
            if (timeout_err && !any) fail_msg("timeout_err_stray", "pulse without completion");
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(iss_q.size() == 0 && done_q.size() == 0 && op0_q.size() == 0 &&
                 op1_q.size() == 0 && !client_busy[0] && !client_busy[1] &&
                 !ctrl_req_read && !ctrl_req_write)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                fail_msg(name, $sformatf("drain timed out, %0d issues %0d completions left",
                                         iss_q.size(), done_q.size()));
                iss_q.delete(); done_q.delete(); op0_q.delete(); op1_q.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #2;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        for (int p = 0; p < 2; p++) begin
            req_read[p] = 1'b0; req_write[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            client_busy[p] = 1'b0;
        end

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_ctrl_req", 64'({ctrl_req_read, ctrl_req_write}), 64'(0));
        check("rst_ctrl_address", 64'(ctrl_address), 64'(0));
        check("rst_ctrl_data_in", 64'(ctrl_data_in), 64'(0));
        check("rst_pulses", 64'({dv[0], wc[0], dv[1], wc[1]}), 64'(0));
        check("rst_p0_rdata", 64'(rdata[0]), 64'(0));
        check("rst_p1_rdata", 64'(rdata[1]), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        #2;

        // Single port-0 read, six-cycle controller latency.
        ctrl_latency = 6;
        exp_iss(1'b1, 24'h000010, 32'h0);
        exp_done(1'b0, 1'b1, 32'h12345678, 1'b0);
        push_op(0, 1'b1, 1'b0, 24'h000010, 32'h0, 1'b0);
        wait_idle("t1_drain", 600);
        check("t1_req_cycles", 64'(last_high_cycles), 64'(6));
        check("t1_p0_rdata_hold", 64'(rdata[0]), 64'(32'h12345678));
        check("t1_p1_rdata", 64'(rdata[1]), 64'(0));

        // Simultaneous writes from reset: port 0 first.
        do_reset();
        ctrl_latency = 3;
        exp_iss(1'b0, 24'h000100, 32'hAAAA5555);
        exp_iss(1'b0, 24'h000200, 32'h0F0F0F0F);
        exp_done(1'b0, 1'b0, 32'h0, 1'b0);
        exp_done(1'b1, 1'b0, 32'h0, 1'b0);
        push_op(0, 1'b0, 1'b1, 24'h000100, 32'hAAAA5555, 1'b0);
        push_op(1, 1'b0, 1'b1, 24'h000200, 32'h0F0F0F0F, 1'b0);
        wait_idle("t2_drain", 600);
        check("t2_rdata_untouched", 64'({rdata[0], rdata[1]}), 64'(0));

        // Continuous reads from both ports: strict alternation.
        do_reset();
        ctrl_latency = 2;
        for (int k = 0; k < 4; k++) begin
            exp_iss(1'b1, 24'(24'h000020 + k), 32'h0);
            exp_iss(1'b1, 24'(24'h000030 + k), 32'h0);
            exp_done(1'b0, 1'b1, 32'hD0000020 + 32'(k), 1'b0);
            exp_done(1'b1, 1'b1, 32'hD0000030 + 32'(k), 1'b0);
            push_op(0, 1'b1, 1'b0, 24'(24'h000020 + k), 32'h0, 1'b0);
            push_op(1, 1'b1, 1'b0, 24'(24'h000030 + k), 32'h0, 1'b0);
        end
        wait_idle("t3_drain", 800);
        check("t3_p0_last", 64'(rdata[0]), 64'(32'hD0000023));
        check("t3_p1_last", 64'(rdata[1]), 64'(32'hD0000033));

        // Read and write together on port 0; wrong-type strobe during the write.
        do_reset();
        ctrl_latency = 5;
        inject_wrong = 1'b1;
        exp_iss(1'b1, 24'h000080, 32'h13579BDF);
        exp_iss(1'b0, 24'h000080, 32'h13579BDF);
        exp_done(1'b0, 1'b1, 32'hD0000080, 1'b0);
        exp_done(1'b0, 1'b0, 32'h0, 1'b0);
        push_op(0, 1'b1, 1'b1, 24'h000080, 32'h13579BDF, 1'b0);
        wait_idle("t4_drain", 600);
        inject_wrong = 1'b0;
        check("t4_p0_rdata_hold", 64'(rdata[0]), 64'(32'hD0000080));

        // Reset two cycles into BUSY; pending port-1 read reissued afterwards.
        do_reset();
        ctrl_latency = 10;
        exp_iss(1'b1, 24'h000040, 32'h0);
        exp_iss(1'b1, 24'h000050, 32'h0);
        exp_done(1'b1, 1'b1, 32'hD0000050, 1'b0);
        push_op(0, 1'b1, 1'b0, 24'h000040, 32'h0, 1'b1);
        push_op(1, 1'b1, 1'b0, 24'h000050, 32'h0, 1'b0);
        n = 0;
        while (!ctrl_req_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ctrl_req_read) fail_msg("t5_issue_wait", "port 0 read never issued");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ctrl_req", 64'({ctrl_req_read, ctrl_req_write}), 64'(0));
        check("t5_rst_ctrl_bus", 64'({ctrl_address, ctrl_data_in}), 64'(0));
        check("t5_rst_pulses", 64'({dv[0], wc[0], dv[1], wc[1], timeout_err}), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_idle("t5_drain", 600);
        check("t5_p0_rdata", 64'(rdata[0]), 64'(0));
        check("t5_p1_rdata", 64'(rdata[1]), 64'(32'hD0000050));

`ifdef DRAM_ARB_TIMEOUT_EN
        // Controller never answers a port-1 read: watchdog abort.
        do_reset();
        ctrl_enable = 1'b0;
        exp_iss(1'b1, 24'h000060, 32'h0);
        exp_done(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        push_op(1, 1'b1, 1'b0, 24'h000060, 32'h0, 1'b0);
        wait_idle("t6_drain", 600);
        ctrl_enable = 1'b1;
        check("t6_busy_cycles", 64'(last_high_cycles), 64'(16));
        check("t6_p1_rdata", 64'(rdata[1]), 64'(32'hDEADBEEF));
        check("t6_p0_untouched", 64'(rdata[0]), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
